// File: rtl/alu_mdu_if.sv
// Request/result bundle between an ALU/MDU client and the alu_mdu core.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid/in_ready : request handshake; A, B and ALUop are valid when in_valid=1.
//   out_valid/out_ready : result handshake; Result, Hi and the flags are valid when out_valid=1.
// Modports: master = client (drives requests, takes results); slave = alu_mdu core.
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [3:0]            ALUop;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;
    logic [DATA_WIDTH-1:0] Hi;
    logic                  Overflow;
    logic                  CarryOut;
    logic                  Zero;

    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, Result, Hi, Overflow, CarryOut, Zero
    );

    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, Result, Hi, Overflow, CarryOut, Zero
    );
endinterface

// File: rtl/alu_mdu.sv
// ALU with iterative unsigned multiply and optional unsigned divide.
// Latency: 1 cycle for ALU ops, DATA_WIDTH+1 cycles for MULTU/DIVU.
// Backpressure: result is held in DONE until out_ready; no request is accepted outside IDLE.
//
// Ports: clk (rising edge), resetn (async active-low), bus (alu_mdu_if.slave).
// Optional feature: define ALU_MDU_DIV_EN to build the restoring divider for DIVU (1101).
// Without it, 1101 behaves as an undefined opcode and no divider logic exists.
module alu_mdu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk,
    input  logic      resetn,
    alu_mdu_if.slave  bus
);
    localparam int SW  = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1100;
`ifdef ALU_MDU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1101;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;            // multiplicand / divisor
    logic [DATA_WIDTH-1:0] result_q, result_d;  // multiplier / dividend, shifts into product low / quotient
    logic [DATA_WIDTH-1:0] hi_q, hi_d;          // product high / partial remainder
    logic [3:0]            op_q, op_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  cy_q, cy_d;
    logic                  zero_q, zero_d;

    // Single-cycle ALU on the live request inputs; registered at the accept edge.
    logic [DATA_WIDTH:0]   add_w, sub_w;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf, alu_cy, alu_def, is_iter;
    logic [SW-1:0]         shamt;

    assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_w = {1'b0, bus.A} - {1'b0, bus.B};
    assign shamt = bus.B[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cy  = 1'b0;
        alu_def = 1'b1;
        case (bus.ALUop)
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_XOR: alu_res = bus.A ^ bus.B;
            OP_NOR: alu_res = ~(bus.A | bus.B);
            OP_ADD: begin
                alu_res = add_w[MSB:0];
                alu_cy  = add_w[DATA_WIDTH];
                alu_ovf = (bus.A[MSB] == bus.B[MSB]) && (add_w[MSB] != bus.A[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_w[MSB:0];
                alu_cy  = sub_w[DATA_WIDTH];   // borrow: A < B unsigned
                alu_ovf = (bus.A[MSB] != bus.B[MSB]) && (sub_w[MSB] != bus.A[MSB]);
            end
            // Direct signed compare, so an overflowing A-B cannot flip the answer.
            OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLL: alu_res = bus.A << shamt;
            OP_SRL: alu_res = bus.A >> shamt;
            OP_SRA: alu_res = $unsigned($signed(bus.A) >>> shamt);
            default: alu_def = 1'b0;
        endcase
    end

`ifdef ALU_MDU_DIV_EN
    assign is_iter = (bus.ALUop == OP_MULTU) || (bus.ALUop == OP_DIVU);
`else
    assign is_iter = (bus.ALUop == OP_MULTU);
`endif

    // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
    // then shift {carry, hi, lo} right by one.
    logic [DATA_WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, hi_q} + (result_q[0] ? {1'b0, b_q} : '0);

`ifdef ALU_MDU_DIV_EN
    // Restoring divide step: bring in the next dividend bit, subtract if it fits.
    // A zero divisor always "fits", which yields quotient all-ones and remainder A.
    logic [DATA_WIDTH:0]   div_shift;
    logic                  div_ge;
    logic [DATA_WIDTH-1:0] div_sub;
    assign div_shift = {hi_q, result_q[MSB]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_sub   = div_shift[MSB:0] - b_q;
`endif

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        result_d = result_q;
        hi_d     = hi_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        cy_d     = cy_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.ALUop;
                    hi_d  = '0;
                    ovf_d = 1'b0;
                    cy_d  = 1'b0;
                    if (is_iter) begin
                        state_d  = BUSY;
                        b_d      = bus.B;
                        result_d = bus.A;
                        cnt_d    = '0;
                        zero_d   = 1'b0;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        cy_d     = alu_cy;
                        // Undefined opcodes report every flag low, Zero included.
                        zero_d   = alu_def && (alu_res == '0);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
`ifdef ALU_MDU_DIV_EN
                if (op_q == OP_DIVU) begin
                    hi_d     = div_ge ? div_sub : div_shift[MSB:0];
                    result_d = {result_q[MSB-1:0], div_ge};
                end else begin
                    hi_d     = mul_sum[DATA_WIDTH:1];
                    result_d = {mul_sum[0], result_q[MSB:1]};
                end
`else
                hi_d     = mul_sum[DATA_WIDTH:1];
                result_d = {mul_sum[0], result_q[MSB:1]};
`endif
                // The last iteration lands on the same edge that enters DONE.
                if (cnt_q == SW'(DATA_WIDTH - 1)) begin
                    state_d = DONE;
                    zero_d  = (result_d == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            b_q      <= '0;
            result_q <= '0;
            hi_q     <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            cy_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            cy_q     <= cy_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Result    = result_q;
    assign bus.Hi        = hi_q;
    assign bus.Overflow  = ovf_q;
    assign bus.CarryOut  = cy_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at DATA_WIDTH=32.
// Latency: measured per operation against hand-computed values.
// Backpressure: exercised by holding out_ready low with in_valid asserted.
module tb_alu_mdu;
    localparam int DW = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.DATA_WIDTH(DW)) bus();

    alu_mdu #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request at the negedge, let it be accepted, then scramble the
    // inputs so any late sampling shows up as a wrong result.
    task automatic start_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        bus.ALUop    = op;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.B        = $urandom;
        bus.ALUop    = OP_SUB;
    endtask

    // lat counts cycles from accept until out_valid is seen (1 = next cycle).
    task automatic wait_done(output int lat, output int rdy_seen);
        lat      = 1;
        rdy_seen = 0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [3:0] op,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] exp_r, input logic [DW-1:0] exp_hi,
                             input logic exp_ov, input logic exp_cy, input logic exp_z,
                             input int exp_lat);
        int lat, rdy_seen;
        chk({tag, "_rdy_pre"}, bus.in_ready, 1);
        start_op(op, a, b);
        wait_done(lat, rdy_seen);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_rdy"}, rdy_seen, 0);
        chk({tag, "_res"}, bus.Result, exp_r);
        chk({tag, "_hi"}, bus.Hi, exp_hi);
        chk({tag, "_ovf"}, bus.Overflow, exp_ov);
        chk({tag, "_cy"}, bus.CarryOut, exp_cy);
        chk({tag, "_zero"}, bus.Zero, exp_z);
        take();
        chk({tag, "_idle"}, bus.in_ready, 1);
        chk({tag, "_vld_off"}, bus.out_valid, 0);
    endtask

    initial begin
        int lat, rdy_seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALUop     = '0;

        // Reset state
        #12;
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_res", bus.Result, 0);
        chk("rst_hi", bus.Hi, 0);
        chk("rst_flags", {bus.Overflow, bus.CarryOut, bus.Zero}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", bus.in_ready, 1);

        // Arithmetic and flags
        run_check("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 0, 1);
        run_check("add_cy",   OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0,        0, 0, 1, 1, 1);
        run_check("sub_brw",  OP_SUB, 32'h0,        32'h1, 32'hFFFFFFFF, 0, 0, 1, 0, 1);
        run_check("sub_ovf",  OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0, 0, 1);
        run_check("slt_ovf",  OP_SLT, 32'h80000000, 32'h1, 32'h1,        0, 0, 0, 0, 1);
        run_check("slt_no",   OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h0, 0, 0, 0, 1, 1);
        run_check("slt_neg",  OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1,        0, 0, 0, 0, 1);

        // Logic
        run_check("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1);
        run_check("or",  OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, 1);
        run_check("xor", OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 1);
        run_check("nor", OP_NOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        0, 0, 0, 1, 1);

        // Shifts
        run_check("sra31", OP_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
        run_check("sra4",  OP_SRA, 32'h80000000, 32'd4,  32'hF8000000, 0, 0, 0, 0, 1);
        run_check("sra0",  OP_SRA, 32'h80000000, 32'd0,  32'h80000000, 0, 0, 0, 0, 1);
        run_check("srl4",  OP_SRL, 32'h80000000, 32'd4,  32'h08000000, 0, 0, 0, 0, 1);
        run_check("sll33", OP_SLL, 32'h1,        32'h21, 32'h2,        0, 0, 0, 0, 1);

        // Undefined opcode
        run_check("undef", 4'b0101, 32'h5, 32'h5, 32'h0, 0, 0, 0, 0, 1);

        // Multiply
        run_check("mul_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 33);
        run_check("mul_sm",  OP_MULTU, 32'd3,        32'd5,        32'd15,       32'h0,        0, 0, 0, 33);
        run_check("mul_z",   OP_MULTU, 32'h10000,    32'h10000,    32'h0,        32'h1,        0, 0, 1, 33);

`ifdef ALU_MDU_DIV_EN
        run_check("div0", OP_DIVU, 32'd7,   32'd0, 32'hFFFFFFFF, 32'd7, 0, 0, 0, 33);
        run_check("div",  OP_DIVU, 32'd100, 32'd7, 32'd14,       32'd2, 0, 0, 0, 33);
`else
        run_check("divu_undef", OP_DIVU, 32'd7, 32'd0, 32'h0, 32'h0, 0, 0, 0, 1);
`endif

        // Backpressure: result held, in_valid ignored while DONE
        start_op(OP_ADD, 32'd2, 32'd3);
        wait_done(lat, rdy_seen);
        chk("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.ALUop    = OP_OR;
            bus.A        = 32'hAAAA0000;
            bus.B        = 32'h0000BBBB;
            @(posedge clk);
            #1;
            chk("bp_res", bus.Result, 32'd5);
            chk("bp_vld", bus.out_valid, 1);
            chk("bp_rdy", bus.in_ready, 0);
        end
        // in_valid stays high across the releasing edge; it must not be accepted there.
        take();
        bus.in_valid = 1'b0;
        chk("bp_idle", bus.in_ready, 1);
        chk("bp_noacc", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("bp_noacc2", bus.out_valid, 0);

        // Reset during BUSY
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #1;
        chk("mrst_busy", bus.in_ready, 0);
        resetn = 1'b0;
        #1;
        chk("mrst_vld", bus.out_valid, 0);
        chk("mrst_res", bus.Result, 0);
        chk("mrst_hi", bus.Hi, 0);
        chk("mrst_rdy", bus.in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rdy_rel", bus.in_ready, 1);
        chk("mrst_vld_rel", bus.out_valid, 0);
        chk("mrst_res_rel", bus.Result, 0);

        // Block still works after the mid-operation reset
        run_check("post_rst", OP_MULTU, 32'd6, 32'd7, 32'd42, 32'h0, 0, 0, 0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; legal values are powers of two from 4 to 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A  input  DATA_WIDTH  operand A.
REQ-007 B  input  DATA_WIDTH  operand B; the shift amount is the low log2(DATA_WIDTH) bits of B.
REQ-008 ALUop  input  4  operation select.
REQ-009 out_valid  output  1  result registers hold a completed operation.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 Result  output  DATA_WIDTH  low result (quotient for divide).
REQ-012 Hi  output  DATA_WIDTH  upper product (MULTU) or remainder (DIVU); 0 for all other ops.
REQ-013 Overflow, CarryOut, Zero  output  1 each  status flags, registered with Result.

Function
REQ-014 Opcodes SHALL be: 0000 AND, 0001 OR, 0011 XOR, 0100 NOR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MULTU, 1101 DIVU; any other code yields Result=0, Hi=0, all flags 0, latency 1.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 Accept occurs when in_valid&&in_ready; A, B, and ALUop SHALL be captured at the accept edge, and later input changes SHALL be ignored.
REQ-017 Non-iterative ops SHALL go IDLE->DONE; out_valid rises on the cycle after accept (latency 1).
REQ-018 MULTU SHALL go IDLE->BUSY, run unsigned shift-add for exactly DATA_WIDTH cycles, then go to DONE; latency DATA_WIDTH+1; {Hi,Result}=A*B with full 2*DATA_WIDTH bits.
REQ-019 In DONE, outputs SHALL hold stable until out_ready=1, then the FSM goes to IDLE on that edge; no new request is accepted in the same cycle.
REQ-020 ADD/SUB: Result=A+B or A-B modulo 2^DATA_WIDTH; Overflow=signed overflow; CarryOut=unsigned carry-out for ADD and unsigned borrow (A<B) for SUB.
REQ-021 For ops other than ADD/SUB, Overflow=0 and CarryOut=0.
REQ-022 SLT: Result=1 if signed A<B, else 0, including the case where the subtraction overflows.
REQ-023 Zero SHALL equal (Result==0) for every op; Hi is not considered.
REQ-024 SRA SHALL replicate A[DATA_WIDTH-1]; a shift amount of 0 returns A unchanged.
REQ-025 in_valid during BUSY or DONE SHALL have no effect.

Reset
REQ-026 On resetn=0 at any time, including mid-BUSY, the FSM SHALL enter IDLE immediately.
REQ-027 On resetn=0, Result, Hi, all flags, and out_valid SHALL be cleared to 0, and the iteration counter SHALL be cleared to 0.
REQ-028 After reset release, in_ready=1 starting from the first clock edge.

Configuration
REQ-029 Macro ALU_MDU_DIV_EN: when defined, DIVU (1101) SHALL be implemented as unsigned restoring division taking exactly DATA_WIDTH BUSY cycles, with latency DATA_WIDTH+1, Result=quotient, and Hi=remainder.
REQ-030 With ALU_MDU_DIV_EN defined, a divisor of 0 SHALL give Result=all ones and Hi=A with the same latency.
REQ-031 Without ALU_MDU_DIV_EN, 1101 SHALL behave as an undefined opcode (REQ-014), and no divider logic SHALL be present.

Verification
REQ-032 ADD A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1, CarryOut=0, Zero=0, out_valid 1 cycle after accept.
REQ-033 SUB A=0, B=1 -> Result=0xFFFFFFFF, CarryOut=1, Overflow=0; SLT A=0x80000000, B=1 -> Result=1.
REQ-034 SRA A=0x80000000, B=31 -> Result=0xFFFFFFFF; SLL A=1, B=0x21 -> Result=2 (only the low 5 bits of B used).
REQ-035 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Result=0x00000001, out_valid exactly 33 cycles after accept, with in_ready=0 throughout.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after a result -> outputs stable and in_valid ignored; assert out_ready -> IDLE on the next edge.
REQ-037 Assert resetn=0 at BUSY cycle 10 of a MULTU -> out_valid=0, Result=0, in_ready=1 after release; with ALU_MDU_DIV_EN defined, DIVU 7/0 -> Result=0xFFFFFFFF, Hi=7.
